// File: rtl/mipi_csi_packet_decoder.sv
// Single-lane CSI-2 packet decoder: sync check, 4-byte header parse, short-packet
// pulses, long-packet payload streaming and CRC skip, one packet per HS burst.
module mipi_csi_packet_decoder #(
  parameter logic [7:0] SYNC_BYTE    = 8'hB8,
  parameter logic [5:0] SHORT_DT_MAX = 6'h0F
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic [5:0]  data_type_o,
  output logic [1:0]  virtual_channel_o,
  output logic [15:0] word_count_o,
  output logic [7:0]  ecc_o,
  output logic        header_valid_o,
  output logic        frame_start_o,
  output logic        frame_end_o,
  output logic        line_start_o,
  output logic        line_end_o,
  output logic [7:0]  payload_o,
  output logic        payload_valid_o,
  output logic        packet_done_o,
  output logic        packet_error_o
);

  // The sync byte is judged on the first valid byte seen from IDLE, so the
  // burst start and the sync check share one state.
  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAYLOAD,
    CRC,
    DROP
  } state_t;

  state_t      state, state_next;
  logic [1:0]  hdr_cnt;
  logic [15:0] pay_cnt;
  logic        crc_cnt;
  logic [7:0]  di_q;
  logic [7:0]  wc_lsb_q;
  logic [7:0]  wc_msb_q;

  logic        load_hdr;
  logic        fwd;
  logic        done_next;
  logic        err_next;
  logic        fs_next, fe_next, ls_next, le_next;
  logic [5:0]  hdr_dt;
  logic [15:0] hdr_wc;

  assign hdr_dt = di_q[5:0];
  assign hdr_wc = {wc_msb_q, wc_lsb_q};

  always_comb begin
    state_next = state;
    load_hdr   = 1'b0;
    fwd        = 1'b0;
    done_next  = 1'b0;
    err_next   = 1'b0;
    fs_next    = 1'b0;
    fe_next    = 1'b0;
    ls_next    = 1'b0;
    le_next    = 1'b0;
    case (state)
      IDLE: begin
        if (byte_valid_i) begin
          if (byte_i == SYNC_BYTE) begin
            state_next = HDR;
          end else begin
            state_next = DROP;
            err_next   = 1'b1;
          end
        end
      end
      HDR: begin
        if (!byte_valid_i) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end else if (hdr_cnt == 2'd3) begin
          load_hdr = 1'b1;
          if (hdr_dt <= SHORT_DT_MAX) begin
            state_next = DROP;
            done_next  = 1'b1;
            fs_next    = (hdr_dt == 6'h00);
            fe_next    = (hdr_dt == 6'h01);
            ls_next    = (hdr_dt == 6'h02);
            le_next    = (hdr_dt == 6'h03);
          end else if (hdr_wc == 16'd0) begin
            state_next = CRC;
          end else begin
            state_next = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (!byte_valid_i) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end else begin
          fwd = 1'b1;
          if (pay_cnt == 16'd1) begin
            state_next = CRC;
          end
        end
      end
      CRC: begin
        if (!byte_valid_i) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end else if (crc_cnt) begin
          state_next = DROP;
          done_next  = 1'b1;
        end
      end
      DROP: begin
        if (!byte_valid_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state             <= IDLE;
      hdr_cnt           <= 2'd0;
      pay_cnt           <= 16'd0;
      crc_cnt           <= 1'b0;
      di_q              <= 8'd0;
      wc_lsb_q          <= 8'd0;
      wc_msb_q          <= 8'd0;
      data_type_o       <= 6'd0;
      virtual_channel_o <= 2'd0;
      word_count_o      <= 16'd0;
      ecc_o             <= 8'd0;
      header_valid_o    <= 1'b0;
      frame_start_o     <= 1'b0;
      frame_end_o       <= 1'b0;
      line_start_o      <= 1'b0;
      line_end_o        <= 1'b0;
      payload_o         <= 8'd0;
      payload_valid_o   <= 1'b0;
      packet_done_o     <= 1'b0;
      packet_error_o    <= 1'b0;
    end else begin
      state           <= state_next;
      header_valid_o  <= load_hdr;
      frame_start_o   <= fs_next;
      frame_end_o     <= fe_next;
      line_start_o    <= ls_next;
      line_end_o      <= le_next;
      payload_valid_o <= fwd;
      packet_done_o   <= done_next;
      packet_error_o  <= err_next;

      if (state == HDR && byte_valid_i) begin
        hdr_cnt <= hdr_cnt + 2'd1;
        case (hdr_cnt)
          2'd0:    di_q     <= byte_i;
          2'd1:    wc_lsb_q <= byte_i;
          2'd2:    wc_msb_q <= byte_i;
          default: ;
        endcase
      end else begin
        hdr_cnt <= 2'd0;
      end

      // Header fields are shadowed during capture so they only change on a complete header.
      if (load_hdr) begin
        data_type_o       <= hdr_dt;
        virtual_channel_o <= di_q[7:6];
        word_count_o      <= hdr_wc;
        ecc_o             <= byte_i;
        pay_cnt           <= hdr_wc;
      end else if (fwd) begin
        pay_cnt <= pay_cnt - 16'd1;
      end

      if (fwd) begin
        payload_o <= byte_i;
      end

      if (state == CRC && byte_valid_i) begin
        crc_cnt <= ~crc_cnt;
      end else begin
        crc_cnt <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mipi_csi_packet_decoder.sv
// Directed bench for mipi_csi_packet_decoder: a table of per-cycle byte/expected-output
// rows, plus hand sequences for long truncation and mid-packet reset.
module tb_mipi_csi_packet_decoder;

  localparam logic [7:0] F_HV = 8'h80;
  localparam logic [7:0] F_FS = 8'h40;
  localparam logic [7:0] F_FE = 8'h20;
  localparam logic [7:0] F_LS = 8'h10;
  localparam logic [7:0] F_LE = 8'h08;
  localparam logic [7:0] F_PV = 8'h04;
  localparam logic [7:0] F_DN = 8'h02;
  localparam logic [7:0] F_ER = 8'h01;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic [5:0]  data_type_o;
  logic [1:0]  virtual_channel_o;
  logic [15:0] word_count_o;
  logic [7:0]  ecc_o;
  logic        header_valid_o;
  logic        frame_start_o, frame_end_o, line_start_o, line_end_o;
  logic [7:0]  payload_o;
  logic        payload_valid_o;
  logic        packet_done_o;
  logic        packet_error_o;

  mipi_csi_packet_decoder dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .byte_i            (byte_i),
    .byte_valid_i      (byte_valid_i),
    .data_type_o       (data_type_o),
    .virtual_channel_o (virtual_channel_o),
    .word_count_o      (word_count_o),
    .ecc_o             (ecc_o),
    .header_valid_o    (header_valid_o),
    .frame_start_o     (frame_start_o),
    .frame_end_o       (frame_end_o),
    .line_start_o      (line_start_o),
    .line_end_o        (line_end_o),
    .payload_o         (payload_o),
    .payload_valid_o   (payload_valid_o),
    .packet_done_o     (packet_done_o),
    .packet_error_o    (packet_error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        v;
    logic [7:0]  b;
    logic [7:0]  flags;
    logic [7:0]  pay;
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
    logic [7:0]  ecc;
  } vec_t;

  vec_t rows[$];

  // Expected header fields; they only move on a row that expects header_valid_o.
  logic [1:0]  m_vc;
  logic [5:0]  m_dt;
  logic [15:0] m_wc;
  logic [7:0]  m_ecc;

  int checks   = 0;
  int failures = 0;

  task automatic applyStimulus(input logic v, input logic [7:0] b);
    @(negedge clk_i);
    byte_valid_i = v;
    byte_i       = b;
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] exp_flags, input logic [7:0] exp_pay);
    logic [7:0] act;
    logic       ok;
    act = {header_valid_o, frame_start_o, frame_end_o, line_start_o, line_end_o,
           payload_valid_o, packet_done_o, packet_error_o};
    ok = (act === exp_flags) && (virtual_channel_o === m_vc) && (data_type_o === m_dt) &&
         (word_count_o === m_wc) && (ecc_o === m_ecc) &&
         (!exp_flags[2] || (payload_o === exp_pay));
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL %s: got flags=%b pay=%h vc=%0d dt=%h wc=%h ecc=%h, expected flags=%b pay=%h vc=%0d dt=%h wc=%h ecc=%h",
               name, act, payload_o, virtual_channel_o, data_type_o, word_count_o, ecc_o,
               exp_flags, exp_pay, m_vc, m_dt, m_wc, m_ecc);
    end
  endtask

  task automatic add_row(input logic v, input logic [7:0] b, input logic [7:0] flags, input logic [7:0] pay);
    vec_t r;
    r.v = v; r.b = b; r.flags = flags; r.pay = pay;
    r.vc = 2'd0; r.dt = 6'd0; r.wc = 16'd0; r.ecc = 8'd0;
    rows.push_back(r);
  endtask

  task automatic add_header(input logic [7:0] di, input logic [7:0] lsb, input logic [7:0] msb,
                            input logic [7:0] ecc, input logic [7:0] extra);
    vec_t r;
    add_row(1'b1, 8'hB8, 8'h00, 8'h00);
    add_row(1'b1, di,    8'h00, 8'h00);
    add_row(1'b1, lsb,   8'h00, 8'h00);
    add_row(1'b1, msb,   8'h00, 8'h00);
    r.v = 1'b1; r.b = ecc; r.flags = F_HV | extra; r.pay = 8'h00;
    r.vc = di[7:6]; r.dt = di[5:0]; r.wc = {msb, lsb}; r.ecc = ecc;
    rows.push_back(r);
  endtask

  task automatic send_header(input string tag, input logic [7:0] di, input logic [7:0] lsb,
                             input logic [7:0] msb, input logic [7:0] ecc, input logic [7:0] extra);
    applyStimulus(1'b1, 8'hB8); checkOutput({tag, "_sync"}, 8'h00, 8'h00);
    applyStimulus(1'b1, di);    checkOutput({tag, "_di"},   8'h00, 8'h00);
    applyStimulus(1'b1, lsb);   checkOutput({tag, "_wcl"},  8'h00, 8'h00);
    applyStimulus(1'b1, msb);   checkOutput({tag, "_wch"},  8'h00, 8'h00);
    applyStimulus(1'b1, ecc);
    m_vc = di[7:6]; m_dt = di[5:0]; m_wc = {msb, lsb}; m_ecc = ecc;
    checkOutput({tag, "_hdr"}, F_HV | extra, 8'h00);
  endtask

  initial begin
    m_vc = 2'd0; m_dt = 6'd0; m_wc = 16'd0; m_ecc = 8'd0;
    reset_i = 1'b1; byte_valid_i = 1'b0; byte_i = 8'h00;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("reset", 8'h00, 8'h00);
    @(negedge clk_i);
    reset_i = 1'b0;

    add_row(1'b0, 8'h00, 8'h00, 8'h00);
    // Frame start short packet, trailing filler ignored.
    add_header(8'h00, 8'h01, 8'h00, 8'hE1, F_FS | F_DN);
    add_row(1'b1, 8'h55, 8'h00, 8'h00);
    add_row(1'b0, 8'h00, 8'h00, 8'h00);
    // Long packet VC1 DT 0x2B WC 5; a second sync-looking byte after CRC must be ignored.
    add_header(8'h6B, 8'h05, 8'h00, 8'h3C, 8'h00);
    for (int i = 0; i < 5; i++) add_row(1'b1, 8'h11 + 8'(i), F_PV, 8'h11 + 8'(i));
    add_row(1'b1, 8'hC1, 8'h00, 8'h00);
    add_row(1'b1, 8'hC2, F_DN, 8'h00);
    add_row(1'b1, 8'hB8, 8'h00, 8'h00);
    add_row(1'b1, 8'h6B, 8'h00, 8'h00);
    add_row(1'b0, 8'h00, 8'h00, 8'h00);
    // Zero-length long packet.
    add_header(8'h2A, 8'h00, 8'h00, 8'h77, 8'h00);
    add_row(1'b1, 8'hD1, 8'h00, 8'h00);
    add_row(1'b1, 8'hD2, F_DN, 8'h00);
    add_row(1'b0, 8'h00, 8'h00, 8'h00);
    // Remaining sync short packets and the short/long DT boundary.
    add_header(8'h01, 8'h02, 8'h00, 8'hF0, F_FE | F_DN);
    add_row(1'b0, 8'h00, 8'h00, 8'h00);
    add_header(8'h82, 8'h03, 8'h00, 8'h11, F_LS | F_DN);
    add_row(1'b0, 8'h00, 8'h00, 8'h00);
    add_header(8'hC3, 8'h10, 8'h00, 8'h45, F_LE | F_DN);
    add_row(1'b0, 8'h00, 8'h00, 8'h00);
    add_header(8'h0F, 8'h00, 8'h00, 8'h12, F_DN);
    add_row(1'b0, 8'h00, 8'h00, 8'h00);
    add_header(8'h10, 8'h01, 8'h00, 8'hEE, 8'h00);
    add_row(1'b1, 8'h99, F_PV, 8'h99);
    add_row(1'b1, 8'hCA, 8'h00, 8'h00);
    add_row(1'b1, 8'hCB, F_DN, 8'h00);
    add_row(1'b0, 8'h00, 8'h00, 8'h00);
    // Bad sync: rest of burst, even a well-formed header, is dropped.
    add_row(1'b1, 8'h47, F_ER, 8'h00);
    add_row(1'b1, 8'hB8, 8'h00, 8'h00);
    add_row(1'b1, 8'h00, 8'h00, 8'h00);
    add_row(1'b1, 8'h01, 8'h00, 8'h00);
    add_row(1'b1, 8'h00, 8'h00, 8'h00);
    add_row(1'b1, 8'hE1, 8'h00, 8'h00);
    add_row(1'b0, 8'h00, 8'h00, 8'h00);
    // Truncated inside the header, then truncated inside the CRC.
    add_row(1'b1, 8'hB8, 8'h00, 8'h00);
    add_row(1'b1, 8'h00, 8'h00, 8'h00);
    add_row(1'b0, 8'h00, F_ER, 8'h00);
    add_header(8'h2A, 8'h00, 8'h00, 8'h78, 8'h00);
    add_row(1'b1, 8'hD1, 8'h00, 8'h00);
    add_row(1'b0, 8'h00, F_ER, 8'h00);

    for (int i = 0; i < rows.size(); i++) begin
      applyStimulus(rows[i].v, rows[i].b);
      if (rows[i].flags[7]) begin
        m_vc = rows[i].vc; m_dt = rows[i].dt; m_wc = rows[i].wc; m_ecc = rows[i].ecc;
      end
      checkOutput($sformatf("row%0d", i), rows[i].flags, rows[i].pay);
    end

    // Long packet WC=100 truncated after 40 payload bytes, then a normal burst.
    send_header("trunc", 8'h2B, 8'h64, 8'h00, 8'h5A, 8'h00);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 8'h20 + 8'(i));
      checkOutput($sformatf("trunc_pay%0d", i), F_PV, 8'h20 + 8'(i));
    end
    applyStimulus(1'b0, 8'h00);
    checkOutput("trunc_err", F_ER, 8'h00);
    send_header("after_trunc", 8'h00, 8'h01, 8'h00, 8'hE1, F_FS | F_DN);
    applyStimulus(1'b0, 8'h00);
    checkOutput("after_trunc_idle", 8'h00, 8'h00);

    // Reset after three header bytes clears everything without a done/error pulse.
    applyStimulus(1'b1, 8'hB8); checkOutput("rst_sync", 8'h00, 8'h00);
    applyStimulus(1'b1, 8'h6B); checkOutput("rst_di",   8'h00, 8'h00);
    applyStimulus(1'b1, 8'h05); checkOutput("rst_wcl",  8'h00, 8'h00);
    applyStimulus(1'b1, 8'h00); checkOutput("rst_wch",  8'h00, 8'h00);
    @(negedge clk_i);
    reset_i = 1'b1; byte_i = 8'h3C;
    @(posedge clk_i);
    #1;
    m_vc = 2'd0; m_dt = 6'd0; m_wc = 16'd0; m_ecc = 8'd0;
    checkOutput("rst_mid", 8'h00, 8'h00);
    @(negedge clk_i);
    reset_i = 1'b0; byte_valid_i = 1'b0; byte_i = 8'h00;
    @(posedge clk_i);
    #1;
    checkOutput("rst_release", 8'h00, 8'h00);
    send_header("post_rst", 8'h6B, 8'h05, 8'h00, 8'h3C, 8'h00);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'hA0 + 8'(i));
      checkOutput($sformatf("post_rst_pay%0d", i), F_PV, 8'hA0 + 8'(i));
    end
    applyStimulus(1'b1, 8'hC1); checkOutput("post_rst_crc1", 8'h00, 8'h00);
    applyStimulus(1'b1, 8'hC2); checkOutput("post_rst_done", F_DN, 8'h00);
    applyStimulus(1'b0, 8'h00); checkOutput("post_rst_idle", 8'h00, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
